// File: rtl/hopfield_pkg.sv
// Shared definitions for the Hopfield training path.
// Contents:
//   - default sizing constants (pixel width, image side, pattern capacity, weight width)
//   - N, the neuron count, and IDX_W, the width of the row/column/address indices
//   - trainState_t, the trainer FSM state encoding
//   - bipolarSignBit(), which maps a ROM pixel to its stored sign bit (1 means -1)
package hopfield_pkg;

    localparam int DEF_MEM_WIDTH    = 16;
    localparam int DEF_IMAGE_WIDTH  = 10;
    localparam int DEF_MAX_SIZE     = 9;
    localparam int DEF_WEIGHT_WIDTH = 8;

    localparam int N     = DEF_IMAGE_WIDTH * DEF_IMAGE_WIDTH;
    localparam int IDX_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CAPTURE,
        EMIT,
        FINISH
    } trainState_t;

    // A pixel with its MSB set reads as a negative number, which is exactly the -1 case.
    function automatic logic bipolarSignBit(input logic signed [DEF_MEM_WIDTH-1:0] pixel);
        return (pixel < 0);
    endfunction

endpackage

// File: rtl/hebbian_weight_calc.sv
// Combinational Hebbian weight for one neuron pair.
// Ports:
//   colI_i    - sign bits of neuron i, one per stored pattern (1 = -1)
//   colJ_i    - sign bits of neuron j, one per stored pattern
//   numPat_i  - number of active patterns P; pattern slots at or above P are ignored
//   weight_o  - signed weight 2a-P, where a is the count of agreeing active patterns
module hebbian_weight_calc
    import hopfield_pkg::*;
#(
    parameter int MAX_SIZE     = DEF_MAX_SIZE,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH
) (
    input  logic [MAX_SIZE-1:0]            colI_i,
    input  logic [MAX_SIZE-1:0]            colJ_i,
    input  logic [7:0]                     numPat_i,
    output logic signed [WEIGHT_WIDTH-1:0] weight_o
);

    logic [7:0]        agreeCount;
    logic signed [9:0] diff;

    // Each agreeing pattern contributes +1 and each disagreeing one -1, so the sum is
    // agreements minus mismatches = 2*agreements - P.
    always_comb begin
        agreeCount = '0;
        for (int k = 0; k < MAX_SIZE; k++) begin
            if ((k < int'(numPat_i)) && (colI_i[k] == colJ_i[k])) begin
                agreeCount = agreeCount + 8'd1;
            end
        end
        diff     = $signed({1'b0, agreeCount, 1'b0}) - $signed({2'b00, numPat_i});
        weight_o = diff[WEIGHT_WIDTH-1:0];
    end

endmodule

// File: rtl/hebbian_trainer.sv
// Hebbian trainer: loads bipolar sign vectors from the pattern ROM, then streams the
// weight matrix w_ij row-major over a valid/ready interface. One run per start pulse.
// Ports:
//   clk, rst_n     - clock and asynchronous active-low reset
//   start          - one-cycle run request, ignored while busy
//   num_patterns   - requested pattern count, clamped to 1..MAX_SIZE on accepted start
//   busy, done     - run in progress / one-cycle completion pulse
//   rom_a          - ROM pattern address
//   rom_image      - ROM image word, pixel k at [k*MEM_WIDTH +: MEM_WIDTH]
//   w_valid/w_ready, w_row, w_col, w_data - weight stream beat (i, j, w_ij)
module hebbian_trainer
    import hopfield_pkg::*;
#(
    parameter int MEM_WIDTH    = DEF_MEM_WIDTH,
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int MAX_SIZE     = DEF_MAX_SIZE,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic [7:0]                                 num_patterns,
    output logic                                       busy,
    output logic                                       done,
    output logic [7:0]                                 rom_a,
    input  logic [MEM_WIDTH*IMAGE_WIDTH*IMAGE_WIDTH-1:0] rom_image,
    output logic                                       w_valid,
    input  logic                                       w_ready,
    output logic [7:0]                                 w_row,
    output logic [7:0]                                 w_col,
    output logic signed [WEIGHT_WIDTH-1:0]             w_data
);

    localparam int NEURONS = IMAGE_WIDTH * IMAGE_WIDTH;
    localparam int ROW_W   = $clog2(NEURONS);
    localparam int PAT_W   = $clog2(MAX_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);

    trainState_t                    state_q;
    logic [7:0]                     numPat_q;
    logic [PAT_W-1:0]               pattIdx_q;
    logic [IDX_W-1:0]               romA_q;
    logic [IDX_W-1:0]               row_q;
    logic [IDX_W-1:0]               col_q;
    logic signed [WEIGHT_WIDTH-1:0] wData_q;
    logic                           wValid_q;
    logic                           busy_q;
    logic                           done_q;
    // Stored transposed: one entry per neuron holding its sign in every pattern slot,
    // so a weight needs just two entry reads.
    logic [MAX_SIZE-1:0]            signStore_q [NEURONS];

    logic [7:0]                     patClamp_d;
    logic [IDX_W-1:0]               nextRow_d;
    logic [IDX_W-1:0]               nextCol_d;
    logic signed [WEIGHT_WIDTH-1:0] calcWeight;
    logic signed [WEIGHT_WIDTH-1:0] nextWeight_d;

    // Clamp the requested pattern count into 1..MAX_SIZE.
    always_comb begin
        patClamp_d = num_patterns;
        if (num_patterns == 8'd0) begin
            patClamp_d = 8'd1;
        end else if (num_patterns > 8'(MAX_SIZE)) begin
            patClamp_d = 8'(MAX_SIZE);
        end
    end

    // Row-major successor of the current beat; its weight is precomputed so the next beat
    // can be registered on the same edge that accepts the current one.
    always_comb begin
        nextCol_d = col_q + 8'd1;
        nextRow_d = row_q;
        if (col_q == LAST_IDX) begin
            nextCol_d = '0;
            nextRow_d = row_q + 8'd1;
        end
        nextWeight_d = (nextRow_d == nextCol_d) ? '0 : calcWeight;
    end

    hebbian_weight_calc #(
        .MAX_SIZE     (MAX_SIZE),
        .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) uWeightCalc (
        .colI_i   (signStore_q[nextRow_d[ROW_W-1:0]]),
        .colJ_i   (signStore_q[nextCol_d[ROW_W-1:0]]),
        .numPat_i (numPat_q),
        .weight_o (calcWeight)
    );

    // Load sweeps ROM addresses with a settle cycle before each capture; emit then walks
    // the matrix, advancing only on a handshake so stalled beats hold still.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            numPat_q  <= 8'd1;
            pattIdx_q <= '0;
            romA_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            wData_q   <= '0;
            wValid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int k = 0; k < NEURONS; k++) begin
                signStore_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        numPat_q  <= patClamp_d;
                        pattIdx_q <= '0;
                        romA_q    <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    for (int k = 0; k < NEURONS; k++) begin
                        signStore_q[k][pattIdx_q] <= bipolarSignBit(rom_image[k*MEM_WIDTH +: MEM_WIDTH]);
                    end
                    if (IDX_W'(pattIdx_q) == (numPat_q - 8'd1)) begin
                        row_q    <= '0;
                        col_q    <= '0;
                        wData_q  <= '0;
                        wValid_q <= 1'b1;
                        state_q  <= EMIT;
                    end else begin
                        pattIdx_q <= pattIdx_q + PAT_W'(1);
                        romA_q    <= IDX_W'(pattIdx_q) + 8'd1;
                        state_q   <= ADDR;
                    end
                end
                EMIT: begin
                    if (w_ready) begin
                        if ((row_q == LAST_IDX) && (col_q == LAST_IDX)) begin
                            wValid_q <= 1'b0;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            romA_q   <= '0;
                            state_q  <= FINISH;
                        end else begin
                            row_q   <= nextRow_d;
                            col_q   <= nextCol_d;
                            wData_q <= nextWeight_d;
                        end
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rom_a   = romA_q;
    assign w_valid = wValid_q;
    assign w_row   = row_q;
    assign w_col   = col_q;
    assign w_data  = wData_q;

endmodule
